// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the BCD-digit UART transmitter.
//   state_t        : per-message sequencing states
//   ASCII_*        : character constants used by the digit mapper
//   calc_div()     : clocks per serial bit, CLK_FREQ/BAUD truncated
//   bcd_to_ascii() : nibble 0-9 -> '0'..'9', anything else -> '?'
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_BIT,
    S_DATA,
    S_STOP_BIT,
    S_FINISH
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] nib);
    return (nib <= 4'd9) ? (ASCII_ZERO + {4'd0, nib}) : ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte -- one 8N1 frame: start bit, 8 data bits LSB first, stop bit.
// Each bit lasts exactly DIV clocks.
// Handshake (valid/ready style): a load is taken on a rising edge when
// load=1 and (busy=0 or done=1). done is high during the last clock of the
// stop bit, so a load in that same cycle starts the next start bit with no
// idle gap. The start bit is driven onto tx on the accepting edge itself.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load, data : frame request and its byte
//   tx         : registered serial line (idle high)
//   busy       : a frame is on the line
//   bit_end    : last clock of the current bit
//   done       : last clock of the stop bit
module uart_tx_byte #(
  parameter int unsigned DIV = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       bit_end,
  output logic       done
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;   // 0 = start, 1..8 = data, 9 = stop
  logic [8:0]       shift;     // bits still to send after the start bit

  assign bit_end = busy && (baud_cnt == CNT_W'(DIV - 1));
  assign done    = bit_end && (bit_cnt == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      busy     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '1;
    end else if (load && (!busy || done)) begin
      tx       <= 1'b0;
      busy     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= {1'b1, data};
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else begin
          tx      <= shift[0];
          shift   <= {1'b1, shift[8:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_digit_tx.sv
// uart_digit_tx -- sends four BCD digits (most significant nibble first) as
// ASCII characters over an 8N1 serial line. Nibbles A-F are sent as '?'.
// Build option: define UART_DIGIT_TX_CRLF_EN to append CR, LF (six frames).
// Ports:
//   Clk_100M : clock
//   Reset    : asynchronous active-low reset
//   Start    : message request, taken when Busy=0 (also in the Done cycle)
//   Digits   : four BCD nibbles, latched when Start is taken
//   Busy     : message in progress
//   Done     : one-cycle pulse at message completion (Busy already low)
//   UART_Tx  : serial line, idle high
module uart_digit_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100000000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic        Clk_100M,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Digits,
  output logic        Busy,
  output logic        Done,
  output logic        UART_Tx
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
`ifdef UART_DIGIT_TX_CRLF_EN
  localparam logic [2:0] LAST_CHAR = 3'd5;
`else
  localparam logic [2:0] LAST_CHAR = 3'd3;
`endif

  state_t      state;
  logic [15:0] digits_q;
  logic [2:0]  char_idx;
  logic [2:0]  data_cnt;

  logic       accept;
  logic       advance;
  logic       tx_load;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_bit_end;
  logic       tx_done;

  function automatic logic [7:0] char_at(input logic [15:0] d,
                                         input logic [2:0]  idx);
    logic [7:0] c;
    case (idx)
      3'd0:    c = bcd_to_ascii(d[15:12]);
      3'd1:    c = bcd_to_ascii(d[11:8]);
      3'd2:    c = bcd_to_ascii(d[7:4]);
      3'd3:    c = bcd_to_ascii(d[3:0]);
`ifdef UART_DIGIT_TX_CRLF_EN
      3'd4:    c = ASCII_CR;
      3'd5:    c = ASCII_LF;
`endif
      default: c = ASCII_QMARK;
    endcase
    return c;
  endfunction

  // The first character comes straight from Digits so the start bit can go
  // out on the accepting edge; later characters come from the latched copy
  // and are loaded in the last stop-bit clock to keep frames contiguous.
  assign accept  = Start && !Busy && !tx_busy;
  assign advance = (state == S_STOP_BIT) && tx_done && (char_idx != LAST_CHAR);
  assign tx_load = accept || advance;
  assign tx_data = accept ? char_at(Digits, 3'd0)
                          : char_at(digits_q, char_idx + 3'd1);

  uart_tx_byte #(
    .DIV (DIV)
  ) u_tx_byte (
    .clk     (Clk_100M),
    .rst_n   (Reset),
    .load    (tx_load),
    .data    (tx_data),
    .tx      (UART_Tx),
    .busy    (tx_busy),
    .bit_end (tx_bit_end),
    .done    (tx_done)
  );

  always_ff @(posedge Clk_100M or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      digits_q <= '0;
      char_idx <= '0;
      data_cnt <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE, S_FINISH: begin
          if (accept) begin
            digits_q <= Digits;
            char_idx <= '0;
            data_cnt <= '0;
            Busy     <= 1'b1;
            state    <= S_START_BIT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START_BIT: begin
          if (tx_bit_end) begin
            data_cnt <= '0;
            state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            if (data_cnt == 3'd7) state <= S_STOP_BIT;
            else                  data_cnt <= data_cnt + 3'd1;
          end
        end
        S_STOP_BIT: begin
          if (tx_done) begin
            if (char_idx == LAST_CHAR) begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              char_idx <= char_idx + 3'd1;
              state    <= S_START_BIT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_digit_tx.md
UART_DIGIT_TX -- requirements
Module: uart_digit_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate in bit/s.
REQ-003 SHALL have port Clk_100M  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port Start  input  1  request to send one message; level sampled each cycle.
REQ-006 SHALL have port Digits  input  16  four BCD nibbles; [15:12] sent first, [3:0] last.
REQ-007 SHALL have port Busy  output  1  high while a message is in progress.
REQ-008 SHALL have port Done  output  1  one-cycle pulse at message completion.
REQ-009 SHALL have port UART_Tx  output  1  serial line, idle high, 8N1.

Function
REQ-010 SHALL use bit period DIV = CLK_FREQ/BAUD with integer truncation (868 clocks at defaults); every bit, including start and stop, lasts exactly DIV cycles.
REQ-011 SHALL accept Start only when Busy=0; on acceptance latch Digits, assert Busy on the next edge, and drive UART_Tx low (start bit) on that same edge.
REQ-012 SHALL ignore Start and Digits changes while Busy=1.
REQ-013 SHALL map each nibble 0-9 to ASCII 0x30+n and any nibble 0xA-0xF to 0x3F ('?').
REQ-014 SHALL send each character as one frame: start bit 0, eight data bits LSB first, one stop bit 1, with frames contiguous (no idle gap between them).
REQ-015 SHALL implement the per-message state machine IDLE -> START_BIT -> DATA (8 bits) -> STOP_BIT -> (next character ? START_BIT : FINISH) -> IDLE, with a character index counting 0..N-1.
REQ-016 SHALL, in FINISH, pulse Done for exactly one cycle, deassert Busy in the same cycle, and keep UART_Tx high.
REQ-017 SHALL accept a Start asserted in the Done cycle, so that back-to-back messages have no extra idle gap beyond that one cycle.
REQ-018 SHALL give a total message time from acceptance to Done of N*10*DIV cycles (34720 at defaults with N=4).
REQ-019 SHALL keep UART_Tx driven by a register, glitch-free.

Reset
REQ-020 SHALL, while Reset=0, force UART_Tx=1, Busy=0, Done=0, state IDLE, and clear all counters, asynchronously.
REQ-021 SHALL abandon any frame in progress when Reset asserts mid-message, without completing it, and SHALL leave the line high.
REQ-022 SHALL accept Start no earlier than the first rising edge after Reset deasserts.

Configuration
REQ-023 SHALL recognise macro UART_DIGIT_TX_CRLF_EN: when defined, N=6 and frames 5 and 6 carry 0x0D then 0x0A; when undefined, N=4 and no terminator is sent.

Structure
REQ-024 SHALL place the state enumeration, the ASCII constants (0x30, 0x3F, 0x0D, 0x0A), and the DIV computation in a shared package uart_pkg.
REQ-025 SHALL use one sub-module, uart_tx_byte, to handle baud counting and the 10-bit frame shift with a load/busy/done handshake; uart_digit_tx SHALL sequence the characters.

Verification
REQ-026 SHALL cover: Digits=0x1234 with Start pulse -> bytes 0x31,0x32,0x33,0x34 decoded at 868 clk/bit; Done 34720 cycles after acceptance.
REQ-027 SHALL cover: Digits=0x9A05 -> bytes 0x39,0x3F,0x30,0x35.
REQ-028 SHALL cover: Start reasserted with Digits=0x5555 at cycle 1000 of a 0x1234 message -> no change to that message; no second message sent.
REQ-029 SHALL cover: Reset=0 at cycle 5000 of a message -> UART_Tx=1 and Busy=0 immediately; a Start after release sends a full, correct message.
REQ-030 SHALL cover: Start held high across Done -> second message begins 1 cycle after Done with a correct start bit.
REQ-031 SHALL cover, with UART_DIGIT_TX_CRLF_EN defined: 0x0000 -> 0x30,0x30,0x30,0x30,0x0D,0x0A; Done at 52080 cycles.
